// File: rtl/dlfloat16_mul_sched.sv
// Round-robin scheduler sharing one DLFloat16 multiplier among NREQ requesters.
// Latency: accept at edge k -> rsp_valid after edge k+1 (operand stage + result stage).
// Backpressure: rsp_ready low stalls S2, then S1; req_ready drops once both stages hold data.

// Combinational DLFloat16 multiply: 1 sign, 6 exponent (bias 31), 9 mantissa bits.
// Mantissa is truncated. 0x0000 is zero; 0xFFFF is the NaN/overflow code.
module dlfloat16_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  logic        sa;
  logic        sb;
  logic [5:0]  ea;
  logic [5:0]  eb;
  logic [8:0]  ma;
  logic [8:0]  mb;
  logic [6:0]  e;
  logic [19:0] m;
  logic [8:0]  man_out;
  logic [5:0]  exp_out;
  logic        unused_low_bits;

  assign sa = a[15];
  assign sb = b[15];
  assign ea = a[14:9];
  assign eb = b[14:9];
  assign ma = a[8:0];
  assign mb = b[8:0];

  // Biased exponent sum; bias is removed only on the normal path.
  assign e = {1'b0, ea} + {1'b0, eb};

  // 10x10 significand product including the hidden ones.
  assign m = 20'({1'b1, ma}) * 20'({1'b1, mb});

  // A product of two [1,2) significands lies in [1,4): bit 19 flags the extra integer bit.
  assign man_out = m[19] ? m[18:10] : m[17:9];
  assign exp_out = 6'(e - 7'd31) + {5'd0, m[19]};

  // The low product bits fall below the truncated mantissa.
  assign unused_low_bits = ^m[8:0];

  // Select between underflow, overflow, the saturation code and the normal product.
  always_comb begin
    p = 16'h0000;
    if (e <= 7'd31) begin
      p = 16'h0000;
    end else if (e > 7'd94) begin
      p = (sa ^ sb) ? 16'hFDFE : 16'h7DFE;
    end else if (e == 7'd94) begin
      p = 16'hFFFF;
    end else if ((a == 16'hFFFF) || (b == 16'hFFFF)) begin
      p = 16'hFFFF;
    end else if ((a == 16'h0000) || (b == 16'h0000)) begin
      p = 16'h0000;
    end else begin
      p = {sa ^ sb, exp_out, man_out};
    end
  end

endmodule

module dlfloat16_mul_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  // Operand stage entry.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [15:0]    a;
    logic [15:0]    b;
  } s1_t;

  // Result stage entry.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [15:0]    dat;
  } s2_t;

  s1_t            s1;
  s2_t            s2;
  logic [IDW-1:0] ptr;

  logic           s2_adv;
  logic           s1_adv;
  logic           s1_acc;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   idx;
  logic [15:0]    gnt_a;
  logic [15:0]    gnt_b;
  logic           accept;
  logic [15:0]    prod;

  // Stall chain: S2 drains on a response handshake or when empty; S1 refills behind it.
  assign s2_adv = !s2.vld | rsp_ready;
  assign s1_adv = s1.vld & s2_adv;
  assign s1_acc = !s1.vld | s2_adv;

  // Rotating priority search starting at ptr; uses only req_valid, never the operands.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[IDW-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    gnt_a = 16'h0000;
    gnt_b = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        gnt_a = req_a[16*i +: 16];
        gnt_b = req_b[16*i +: 16];
      end
    end
  end

  // One-hot ready to the granted requester; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (gnt_found && !rst) begin
      req_ready[gnt_id] = s1_acc;
    end
  end

  assign accept = gnt_found & s1_acc & !rst;

  // Pointer moves just past the requester that was served, giving round-robin fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Operand stage: refills whenever it can accept; a bubble clears the valid bit only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (s1_acc) begin
      s1.vld <= accept;
      if (accept) begin
        s1.id <= gnt_id;
        s1.a  <= gnt_a;
        s1.b  <= gnt_b;
      end
    end
  end

  dlfloat16_mul u_mul (
    .a (s1.a),
    .b (s1.b),
    .p (prod)
  );

  // Result stage: captures the product whenever the consumer side can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
    end else if (s2_adv) begin
      s2.vld <= s1.vld;
      s2.id  <= s1.id;
      s2.dat <= prod;
    end
  end

  assign rsp_valid = s2.vld;
  assign rsp_id    = s2.id;
  assign rsp_data  = s2.dat;
  assign busy      = s1.vld | s2.vld;

  // s1_adv documents the S1->S2 transfer condition; S2 loads on s2_adv alone.
  logic unused_s1_adv;
  assign unused_s1_adv = s1_adv;

endmodule

// File: tb/tb_dlfloat16_mul_sched.sv
module tb_dlfloat16_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_a;
  logic [16*NREQ-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_data;
  logic                busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_prod [NREQ];
  int          exp_id_q [$];
  logic [15:0] exp_dat_q [$];
  int          grant_log [$];

  logic [15:0] sp_a [6];
  logic [15:0] sp_b [6];
  logic [15:0] sp_p [6];

  dlfloat16_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: record accepts and compare each response handshake in order.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_id_q.push_back(i);
          exp_dat_q.push_back(exp_prod[i]);
          grant_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          check("rsp_id", 32'(rsp_id), exp_id_q.pop_front());
          check("rsp_data", 32'(rsp_data), 32'(exp_dat_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    exp_prod[i]       = e;
    req_valid[i]      = 1'b1;
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    logic done = 1'b0;
    set_req(i, a, b, e);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = req_ready[i];
      tick();
    end
    req_valid[i] = 1'b0;
    check("accept_in_time", 32'(done), 1);
  endtask

  task automatic drain(input string tag);
    logic idle = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
    end
    check({tag, "_idle"}, 32'(idle), 1);
    check({tag, "_sb_empty"}, exp_id_q.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_id_q.delete();
    exp_dat_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          cyc;
    logic        held_vld;
    logic [15:0] held_dat;
    logic [IDW-1:0] held_id;

    sp_a[0] = 16'h3E00; sp_b[0] = 16'h0000; sp_p[0] = 16'h0000;
    sp_a[1] = 16'hFFFF; sp_b[1] = 16'h3E00; sp_p[1] = 16'hFFFF;
    sp_a[2] = 16'h7C00; sp_b[2] = 16'h7C00; sp_p[2] = 16'h7DFE;
    sp_a[3] = 16'hFC00; sp_b[3] = 16'h7C00; sp_p[3] = 16'hFDFE;
    sp_a[4] = 16'h0200; sp_b[4] = 16'h0200; sp_p[4] = 16'h0000;
    sp_a[5] = 16'h3E00; sp_b[5] = 16'h3E00; sp_p[5] = 16'h3E00;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_prod[i] = 16'h0000;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;

    // Single request: 2.0 x 3.0, latency check
    set_req(0, 16'h4000, 16'h4100, 16'h4300);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_rsp_early", 32'(rsp_valid), 0);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_id", 32'(rsp_id), 0);
    check("t1_rsp_data", 32'(rsp_data), 32'h4300);
    tick();
    drain("t1");

    // Normalisation shift: 3.0 x 3.0 = 9.0 on requester 2
    send(2, 16'h4100, 16'h4100, 16'h4440);
    drain("t2");

    // Special values
    for (int k = 0; k < 6; k++) send(1, sp_a[k], sp_b[k], sp_p[k]);
    drain("special");

    // Round robin from a fresh pointer
    do_reset();
    grant_log.delete();
    set_req(0, 16'h4000, 16'h4100, 16'h4300);
    set_req(1, 16'h4100, 16'h4100, 16'h4440);
    set_req(2, 16'h3E00, 16'h3E00, 16'h3E00);
    set_req(3, 16'h4000, 16'h4000, 16'h4200);
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 40) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      cyc++;
      tick();
    end
    req_valid = '0;
    check("rr_accepts", acc, 8);
    check("rr_cycles", cyc, 8);
    for (int k = 0; k < 8; k++) begin
      check("rr_order", (grant_log.size() > k) ? grant_log[k] : -1, k % 4);
    end
    drain("rr");

    // Backpressure: pipeline fills to two entries and holds its output
    rsp_ready = 1'b0;
    grant_log.delete();
    set_req(0, 16'h4100, 16'h4100, 16'h4440);
    set_req(1, 16'h4000, 16'h4000, 16'h4200);
    acc      = 0;
    held_vld = 1'b0;
    held_dat = 16'h0000;
    held_id  = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      if (rsp_valid) begin
        if (!held_vld) begin
          held_vld = 1'b1;
          held_dat = rsp_data;
          held_id  = rsp_id;
        end else begin
          check("bp_data_stable", 32'(rsp_data), 32'(held_dat));
          check("bp_id_stable", 32'(rsp_id), 32'(held_id));
        end
      end
      tick();
    end
    @(negedge clk);
    check("bp_accepts", acc, 2);
    check("bp_ready_low", 32'(req_ready), 0);
    check("bp_busy", 32'(busy), 1);
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    check("bp_held_data", 32'(held_dat), 32'h4440);
    check("bp_held_id", 32'(held_id), 0);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("bp");
    check("bp_order0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("bp_order1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

    // Reset with two entries in flight; pointer must return to requester 0
    rsp_ready = 1'b0;
    set_req(1, 16'h4100, 16'h4100, 16'h4440);
    set_req(2, 16'h4000, 16'h4000, 16'h4200);
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 20) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      cyc++;
      tick();
    end
    req_valid = '0;
    check("mr_accepts", acc, 2);
    check("mr_busy_before", 32'(busy), 1);
    check("mr_rsp_before", 32'(rsp_valid), 1);
    rst = 1'b1;
    exp_id_q.delete();
    exp_dat_q.delete();
    #1;
    check("mr_rsp_valid_drop", 32'(rsp_valid), 0);
    check("mr_busy_drop", 32'(busy), 0);
    tick();
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    set_req(3, 16'h4000, 16'h4100, 16'h4300);
    set_req(0, 16'h3E00, 16'h3E00, 16'h3E00);
    @(negedge clk);
    check("mr_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("mr_second_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    drain("mr");

    check("sb_final", exp_id_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
